// File: rtl/fencer_action_fsm.sv
// Per-player fencing action controller: latches IR commands, samples frame data and steps
// the rest/block/lunge/attack/score/recover/dead machine once per frame.
module fencer_action_fsm #(
    parameter int unsigned COORD_X_W         = 11,
    parameter int unsigned COORD_Y_W         = 10,
    parameter int unsigned HEALTH_W          = 3,
    parameter int unsigned HEALTH_INIT       = 5,
    parameter int unsigned ATTACK_MAX_FRAMES = 30,
    parameter int unsigned BLOCK_MAX_FRAMES  = 90,
    parameter int unsigned RECOVER_FRAMES    = 20
) (
    input  logic                 clk_pixel_in,
    input  logic                 rst_in,
    input  logic                 ir_in_valid,
    input  logic                 block_in,
    input  logic                 lunge_in,
    input  logic                 release_in,
    input  logic                 frame_valid_in,
    input  logic [COORD_X_W-1:0] saber_x_in,
    input  logic [COORD_Y_W-1:0] saber_y_in,
    input  logic                 opponent_scored_in,
    input  logic                 attack_hit_in,
    input  logic                 saber_clash_in,
    output logic [1:0]           saber_state_out,
    output logic [COORD_X_W-1:0] attack_x_out,
    output logic [COORD_Y_W-1:0] attack_y_out,
    output logic [HEALTH_W-1:0]  health_out,
    output logic                 player_scored_out,
    output logic                 game_over_out,
    output logic                 data_out_valid
);

    localparam int unsigned MAX_AB  = (ATTACK_MAX_FRAMES > BLOCK_MAX_FRAMES) ?
                                      ATTACK_MAX_FRAMES : BLOCK_MAX_FRAMES;
    localparam int unsigned MAX_ALL = (MAX_AB > RECOVER_FRAMES) ? MAX_AB : RECOVER_FRAMES;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0]    ATK_LAST = CNT_W'(ATTACK_MAX_FRAMES - 1);
    localparam logic [CNT_W-1:0]    BLK_LAST = CNT_W'(BLOCK_MAX_FRAMES - 1);
    localparam logic [CNT_W-1:0]    REC_LAST = CNT_W'(RECOVER_FRAMES - 1);
    localparam logic [HEALTH_W-1:0] HP_INIT  = HEALTH_W'(HEALTH_INIT);
    localparam bit                  BLK_LIMITED = (BLOCK_MAX_FRAMES != 0);

    typedef enum logic [2:0] {
        StRest,
        StBlock,
        StLunge,
        StAttack,
        StScore,
        StRecover,
        StDead
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [HEALTH_W-1:0]  health_q, health_d;
    logic [COORD_X_W-1:0] atk_x_q, atk_x_d;
    logic [COORD_Y_W-1:0] atk_y_q, atk_y_d;
    logic                 scored_q, scored_d;

    logic                 blk_q, lng_q, rel_q;
    logic                 step_pending_q, step, beat_q;
    logic [COORD_X_W-1:0] smp_x_q;
    logic [COORD_Y_W-1:0] smp_y_q;
    logic                 smp_opp_q, smp_hit_q, smp_clash_q;

    logic [1:0]           saber_code;
    logic                 show_atk;

    // A new frame strobe arriving while a step is pending overwrites the sample and
    // postpones the step, so back-to-back strobes produce a single step.
    assign step = step_pending_q & ~frame_valid_in;

    // Sticky commands clear on the step cycle; a command arriving on that same edge is kept.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            blk_q <= 1'b0;
            lng_q <= 1'b0;
            rel_q <= 1'b0;
        end else if (step) begin
            blk_q <= ir_in_valid & block_in;
            lng_q <= ir_in_valid & lunge_in;
            rel_q <= ir_in_valid & release_in;
        end else if (ir_in_valid) begin
            blk_q <= blk_q | block_in;
            lng_q <= lng_q | lunge_in;
            rel_q <= rel_q | release_in;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            step_pending_q <= 1'b0;
            smp_x_q        <= '0;
            smp_y_q        <= '0;
            smp_opp_q      <= 1'b0;
            smp_hit_q      <= 1'b0;
            smp_clash_q    <= 1'b0;
        end else begin
            step_pending_q <= frame_valid_in;
            if (frame_valid_in) begin
                smp_x_q     <= saber_x_in;
                smp_y_q     <= saber_y_in;
                smp_opp_q   <= opponent_scored_in;
                smp_hit_q   <= attack_hit_in;
                smp_clash_q <= saber_clash_in;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        health_d = health_q;
        atk_x_d  = atk_x_q;
        atk_y_d  = atk_y_q;
        scored_d = scored_q;

        if (step) begin
            scored_d = 1'b0;
            unique case (state_q)
                StRest: begin
                    if (blk_q) begin
                        state_d = StBlock;
                    end else if (lng_q) begin
                        state_d = StLunge;
                        atk_x_d = smp_x_q;
                        atk_y_d = smp_y_q;
                    end
                end
                StBlock: begin
                    if (rel_q) begin
                        state_d = StRest;
                    end else if (BLK_LIMITED && cnt_q == BLK_LAST) begin
                        state_d = StRecover;
                    end
                end
                StLunge: state_d = StAttack;
                StAttack: begin
                    if (rel_q && smp_hit_q) begin
                        state_d  = StScore;
                        scored_d = 1'b1;
                    end else if (smp_clash_q || rel_q || cnt_q == ATK_LAST) begin
                        state_d = StRecover;
                    end
                end
                StScore: state_d = StRecover;
                StRecover: begin
                    if (cnt_q == REC_LAST) begin
                        state_d = StRest;
                    end
                end
                StDead: state_d = StDead;
                default: state_d = StRest;
            endcase

            // Losing the last point wins over any move, but a simultaneous hit still scores.
            if (smp_opp_q && health_q != '0) begin
                health_d = health_q - 1'b1;
                if (health_d == '0) begin
                    state_d = StDead;
                end
            end

            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_q  <= StRest;
            cnt_q    <= '0;
            health_q <= HP_INIT;
            atk_x_q  <= '0;
            atk_y_q  <= '0;
            scored_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            health_q <= health_d;
            atk_x_q  <= atk_x_d;
            atk_y_q  <= atk_y_d;
            scored_q <= scored_d;
        end
    end

    always_comb begin
        saber_code = 2'b00;
        show_atk   = 1'b0;
        unique case (state_q)
            StLunge: begin
                saber_code = 2'b01;
                show_atk   = 1'b1;
            end
            StBlock:  saber_code = 2'b10;
            StAttack: begin
                saber_code = 2'b11;
                show_atk   = 1'b1;
            end
            StScore:  show_atk = 1'b1;
            default: begin
                saber_code = 2'b00;
                show_atk   = 1'b0;
            end
        endcase
    end

    // Outputs are captured one cycle after the step and held until the next beat.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            beat_q            <= 1'b0;
            data_out_valid    <= 1'b0;
            saber_state_out   <= 2'b00;
            attack_x_out      <= '0;
            attack_y_out      <= '0;
            health_out        <= HP_INIT;
            player_scored_out <= 1'b0;
            game_over_out     <= 1'b0;
        end else begin
            beat_q         <= step;
            data_out_valid <= beat_q;
            if (beat_q) begin
                saber_state_out   <= saber_code;
                attack_x_out      <= show_atk ? atk_x_q : '0;
                attack_y_out      <= show_atk ? atk_y_q : '0;
                health_out        <= health_q;
                player_scored_out <= scored_q;
                game_over_out     <= (state_q == StDead);
            end
        end
    end

endmodule

// File: tb/tb_fencer_action_fsm.sv
// Scoreboard bench for fencer_action_fsm: each frame pushes its expected beat, the observed
// beat is queued when data_out_valid appears, and each scenario compares the pairs.
module tb_fencer_action_fsm;

    typedef struct packed {
        logic [1:0]  st;
        logic [10:0] ax;
        logic [9:0]  ay;
        logic [2:0]  hp;
        logic        sc;
        logic        go;
        logic        extra;
    } beat_t;

    logic        clk_pixel_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        ir_in_valid = 1'b0;
    logic        block_in = 1'b0;
    logic        lunge_in = 1'b0;
    logic        release_in = 1'b0;
    logic        frame_valid_in = 1'b0;
    logic [10:0] saber_x_in = '0;
    logic [9:0]  saber_y_in = '0;
    logic        opponent_scored_in = 1'b0;
    logic        attack_hit_in = 1'b0;
    logic        saber_clash_in = 1'b0;
    logic [1:0]  saber_state_out;
    logic [10:0] attack_x_out;
    logic [9:0]  attack_y_out;
    logic [2:0]  health_out;
    logic        player_scored_out;
    logic        game_over_out;
    logic        data_out_valid;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    fencer_action_fsm #(
        .BLOCK_MAX_FRAMES(4)
    ) dut (
        .clk_pixel_in      (clk_pixel_in),
        .rst_in            (rst_in),
        .ir_in_valid       (ir_in_valid),
        .block_in          (block_in),
        .lunge_in          (lunge_in),
        .release_in        (release_in),
        .frame_valid_in    (frame_valid_in),
        .saber_x_in        (saber_x_in),
        .saber_y_in        (saber_y_in),
        .opponent_scored_in(opponent_scored_in),
        .attack_hit_in     (attack_hit_in),
        .saber_clash_in    (saber_clash_in),
        .saber_state_out   (saber_state_out),
        .attack_x_out      (attack_x_out),
        .attack_y_out      (attack_y_out),
        .health_out        (health_out),
        .player_scored_out (player_scored_out),
        .game_over_out     (game_over_out),
        .data_out_valid    (data_out_valid)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic beat_t mk(input logic [1:0] st, input int ax, input int ay, input int hp,
                                 input logic sc, input logic go);
        beat_t b;
        b.st = st;
        b.ax = 11'(ax);
        b.ay = 10'(ay);
        b.hp = 3'(hp);
        b.sc = sc;
        b.go = go;
        b.extra = 1'b0;
        return b;
    endfunction

    function automatic string fmt(input beat_t b);
        return $sformatf("st=%b ax=%0d ay=%0d hp=%0d sc=%b go=%b longbeat=%b",
                         b.st, b.ax, b.ay, b.hp, b.sc, b.go, b.extra);
    endfunction

    task automatic apply_reset();
        rst_in = 1'b1;
        repeat (2) @(negedge clk_pixel_in);
        rst_in = 1'b0;
        @(negedge clk_pixel_in);
    endtask

    // One frame: optional command before the strobe (or on the step edge when late=1).
    task automatic send_frame(input logic b, input logic l, input logic r, input int x,
                              input int y, input logic opp, input logic hit, input logic clash,
                              input logic late, input beat_t exp);
        beat_t o;
        logic got;
        if (!late && (b || l || r)) begin
            ir_in_valid = 1'b1;
            block_in = b;
            lunge_in = l;
            release_in = r;
            @(negedge clk_pixel_in);
            ir_in_valid = 1'b0;
            block_in = 1'b0;
            lunge_in = 1'b0;
            release_in = 1'b0;
        end
        frame_valid_in = 1'b1;
        saber_x_in = 11'(x);
        saber_y_in = 10'(y);
        opponent_scored_in = opp;
        attack_hit_in = hit;
        saber_clash_in = clash;
        @(negedge clk_pixel_in);
        frame_valid_in = 1'b0;
        opponent_scored_in = 1'b0;
        attack_hit_in = 1'b0;
        saber_clash_in = 1'b0;
        if (late) begin
            ir_in_valid = 1'b1;
            block_in = b;
            lunge_in = l;
            release_in = r;
            @(negedge clk_pixel_in);
            ir_in_valid = 1'b0;
            block_in = 1'b0;
            lunge_in = 1'b0;
            release_in = 1'b0;
        end
        o = 'x;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (data_out_valid) begin
                got = 1'b1;
                o.st = saber_state_out;
                o.ax = attack_x_out;
                o.ay = attack_y_out;
                o.hp = health_out;
                o.sc = player_scored_out;
                o.go = game_over_out;
            end
            @(negedge clk_pixel_in);
        end
        if (got) o.extra = data_out_valid;
        @(negedge clk_pixel_in);
        exp_q.push_back(exp);
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        beat_t e, o;
        apply_reset();
        checks++;
        if ({saber_state_out, attack_x_out, attack_y_out} !== '0) begin
            errors++;
            $display("FAIL reset_saber got st=%b ax=%0d ay=%0d want 0", saber_state_out,
                     attack_x_out, attack_y_out);
        end
        checks++;
        if (health_out !== 3'd5) begin
            errors++;
            $display("FAIL reset_health got %0d want 5", health_out);
        end
        checks++;
        if ({player_scored_out, game_over_out, data_out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got sc=%b go=%b dv=%b want 000", player_scored_out,
                     game_over_out, data_out_valid);
        end
        repeat (3) send_frame(0, 0, 0, 33, 44, 0, 0, 0, 0, mk(2'b00, 0, 0, 5, 0, 0));
        for (int n = 0; exp_q.size() != 0; n++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL idle beat %0d got %s want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_lunge_score();
        beat_t e, o;
        apply_reset();
        send_frame(0, 1, 0, 100, 200, 0, 0, 0, 0, mk(2'b01, 100, 200, 5, 0, 0));
        send_frame(0, 0, 0, 1, 2, 0, 0, 0, 0, mk(2'b11, 100, 200, 5, 0, 0));
        send_frame(0, 0, 1, 3, 4, 0, 1, 0, 0, mk(2'b00, 100, 200, 5, 1, 0));
        send_frame(0, 0, 0, 5, 6, 0, 0, 0, 0, mk(2'b00, 0, 0, 5, 0, 0));
        // 20 RECOVER frames; lunges during them must be ignored
        repeat (20) send_frame(0, 1, 0, 9, 9, 0, 0, 0, 0, mk(2'b00, 0, 0, 5, 0, 0));
        send_frame(0, 1, 0, 7, 9, 0, 0, 0, 0, mk(2'b01, 7, 9, 5, 0, 0));
        for (int n = 0; exp_q.size() != 0; n++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lunge_score beat %0d got %s want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_attack_timeout();
        beat_t e, o;
        apply_reset();
        send_frame(0, 1, 0, 5, 6, 0, 0, 0, 0, mk(2'b01, 5, 6, 5, 0, 0));
        repeat (30) send_frame(0, 0, 0, 0, 0, 0, 1, 0, 0, mk(2'b11, 5, 6, 5, 0, 0));
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b00, 0, 0, 5, 0, 0));
        for (int n = 0; exp_q.size() != 0; n++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL attack_timeout beat %0d got %s want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_block();
        beat_t e, o;
        apply_reset();
        repeat (4) send_frame(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b10, 0, 0, 5, 0, 0));
        send_frame(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b00, 0, 0, 5, 0, 0));
        // in RECOVER now, so a fresh block request stays at 00
        send_frame(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b00, 0, 0, 5, 0, 0));
        apply_reset();
        send_frame(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b10, 0, 0, 5, 0, 0));
        send_frame(1, 0, 1, 0, 0, 0, 0, 0, 0, mk(2'b00, 0, 0, 5, 0, 0));
        send_frame(0, 1, 0, 12, 34, 0, 0, 0, 0, mk(2'b01, 12, 34, 5, 0, 0));
        for (int n = 0; exp_q.size() != 0; n++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL block beat %0d got %s want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_health();
        beat_t e, o;
        apply_reset();
        for (int h = 4; h >= 0; h--) begin
            send_frame(0, 0, 0, 0, 0, 1, 0, 0, 0, mk(2'b00, 0, 0, h, 0, h == 0));
        end
        send_frame(0, 1, 0, 50, 60, 1, 0, 0, 0, mk(2'b00, 0, 0, 0, 0, 1));
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b00, 0, 0, 0, 0, 1));
        for (int n = 0; exp_q.size() != 0; n++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL health beat %0d got %s want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_double_hit();
        beat_t e, o;
        apply_reset();
        for (int h = 4; h >= 1; h--) begin
            send_frame(0, 0, 0, 0, 0, 1, 0, 0, 0, mk(2'b00, 0, 0, h, 0, 0));
        end
        send_frame(0, 1, 0, 8, 9, 0, 0, 0, 0, mk(2'b01, 8, 9, 1, 0, 0));
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b11, 8, 9, 1, 0, 0));
        send_frame(0, 0, 1, 0, 0, 1, 1, 0, 0, mk(2'b00, 0, 0, 0, 1, 1));
        for (int n = 0; exp_q.size() != 0; n++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL double_hit beat %0d got %s want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_clash_and_late_cmd();
        beat_t e, o;
        apply_reset();
        send_frame(0, 1, 0, 3, 3, 0, 0, 0, 0, mk(2'b01, 3, 3, 5, 0, 0));
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b11, 3, 3, 5, 0, 0));
        send_frame(0, 0, 0, 0, 0, 0, 1, 1, 0, mk(2'b00, 0, 0, 5, 0, 0));
        apply_reset();
        // lunge arrives on the step edge: not used this frame, used next frame
        send_frame(0, 1, 0, 20, 21, 0, 0, 0, 1, mk(2'b00, 0, 0, 5, 0, 0));
        send_frame(0, 0, 0, 22, 23, 0, 0, 0, 0, mk(2'b01, 22, 23, 5, 0, 0));
        for (int n = 0; exp_q.size() != 0; n++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL clash_late beat %0d got %s want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        int beats;
        apply_reset();
        send_frame(0, 1, 0, 40, 41, 0, 0, 0, 0, mk(2'b01, 40, 41, 5, 0, 0));
        frame_valid_in = 1'b1;
        @(negedge clk_pixel_in);
        frame_valid_in = 1'b0;
        rst_in = 1'b1;
        @(negedge clk_pixel_in);
        checks++;
        if ({saber_state_out, attack_x_out, attack_y_out, health_out, player_scored_out,
             game_over_out, data_out_valid} !== {2'b00, 11'd0, 10'd0, 3'd5, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid_values got st=%b ax=%0d ay=%0d hp=%0d sc=%b go=%b dv=%b",
                     saber_state_out, attack_x_out, attack_y_out, health_out,
                     player_scored_out, game_over_out, data_out_valid);
        end
        @(negedge clk_pixel_in);
        rst_in = 1'b0;
        beats = 0;
        repeat (8) begin
            @(negedge clk_pixel_in);
            if (data_out_valid) beats++;
        end
        checks++;
        if (beats != 0) begin
            errors++;
            $display("FAIL reset_mid_no_beat got %0d beats want 0", beats);
        end
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(2'b00, 0, 0, 5, 0, 0));
        for (int n = 0; exp_q.size() != 0; n++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid beat %0d got %s want %s", n, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lunge_score();
        test_attack_timeout();
        test_block();
        test_health();
        test_double_hit();
        test_clash_and_late_cmd();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
